// File: rtl/imem_loader_if.sv
// Host word stream and instruction-memory byte write bus for imem_loader.
interface imem_loader_if #(
  parameter int ADDR_W = 11
);
  logic              in_valid;
  logic              in_ready;
  logic [0:31]       in_word;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [0:7]        mem_wdata;

  modport master (
    output in_valid, in_word, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_word, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Serialises host instruction words big-endian into byte writes and holds the core until loaded.
// Optional zero fill of the unused memory tail: define IMEM_ZERO_FILL_EN.
module imem_loader #(
  parameter int IMEM_BYTES = 2048,
  parameter int ADDR_W     = 11,
  parameter int CNT_W      = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_start,
  imem_loader_if.slave     bus,
  output logic             core_hold,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
`ifdef IMEM_ZERO_FILL_EN
    S_FILL,
`endif
    S_ERR
  } state_e;

  localparam logic [ADDR_W:0] IMEM_END = (ADDR_W+1)'(IMEM_BYTES);
`ifdef IMEM_ZERO_FILL_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_BYTES - 1);
`endif

  state_e            state_q;
  logic [0:31]       word_q;
  logic              last_q;
  logic [1:0]        byte_q;
  logic [ADDR_W:0]   ptr_q;
  logic [CNT_W:0]    cnt_q;
  logic              in_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [0:7]        wdata_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  logic [1:0]        byte_d;
  logic [ADDR_W:0]   ptr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [0:7]        wdata_d;

  always_comb begin
    byte_d = byte_q + 2'd1;
    ptr_d  = ptr_q + (ADDR_W+1)'(4);
    addr_d = ptr_q[ADDR_W-1:0] + ADDR_W'(byte_d);
    case (byte_d)
      2'd0:    wdata_d = word_q[0:7];
      2'd1:    wdata_d = word_q[8:15];
      2'd2:    wdata_d = word_q[16:23];
      default: wdata_d = word_q[24:31];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      last_q     <= 1'b0;
      byte_q     <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (load_start) begin
            state_q    <= S_ACCEPT;
            in_ready_q <= 1'b1;
            hold_q     <= 1'b1;
            cnt_q      <= '0;
            ptr_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (bus.in_valid && in_ready_q) begin
            state_q    <= S_WRITE;
            word_q     <= bus.in_word;
            last_q     <= bus.in_last;
            byte_q     <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b1;
            addr_q     <= ptr_q[ADDR_W-1:0];
            wdata_q    <= bus.in_word[0:7];
          end
        end
        S_WRITE: begin
          if (byte_q != 2'd3) begin
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
          end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_q + (CNT_W+1)'(1);
            we_q  <= 1'b0;
            // last word wins over overflow, so an image that exactly fills memory completes
            if (last_q) begin
`ifdef IMEM_ZERO_FILL_EN
              if (ptr_d == IMEM_END) begin
                state_q <= S_DONE;
                hold_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_FILL;
                we_q    <= 1'b1;
                addr_q  <= ptr_d[ADDR_W-1:0];
                wdata_q <= '0;
              end
`else
              state_q <= S_DONE;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else if (ptr_d == IMEM_END) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q    <= S_ACCEPT;
              in_ready_q <= 1'b1;
            end
          end
        end
`ifdef IMEM_ZERO_FILL_EN
        S_FILL: begin
          if (addr_q == LAST_ADDR) begin
            state_q <= S_DONE;
            we_q    <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
`endif
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_hold     = hold_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign word_count    = cnt_q;

endmodule
